// File: rtl/grf_wport_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, side-unit request,
// decode-stage hazard query and the merged register-file write.
interface grf_wport_arbiter_if;
  logic        W_RegWrite;
  logic [4:0]  W_WRA;
  logic [31:0] W_WRD;
  logic [31:0] W_PC;
  logic        X_valid;
  logic [4:0]  X_WRA;
  logic [31:0] X_WRD;
  logic [31:0] X_PC;
  logic        X_ready;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic        pend_stall;
  logic        stall_req;
  logic        D_RegWrite;
  logic [4:0]  D_WRA;
  logic [31:0] D_WRD;
  logic [31:0] D_PCWhenWrite;

  modport master (
    output W_RegWrite, W_WRA, W_WRD, W_PC,
    output X_valid, X_WRA, X_WRD, X_PC,
    output D_rs, D_rt,
    input  X_ready, pend_stall, stall_req,
    input  D_RegWrite, D_WRA, D_WRD, D_PCWhenWrite
  );

  modport slave (
    input  W_RegWrite, W_WRA, W_WRD, W_PC,
    input  X_valid, X_WRA, X_WRD, X_PC,
    input  D_rs, D_rt,
    output X_ready, pend_stall, stall_req,
    output D_RegWrite, D_WRA, D_WRD, D_PCWhenWrite
  );
endinterface

// File: rtl/grf_wport_arbiter.sv
// Shares the single register-file write port between the pipeline writeback
// (always wins) and a small FIFO of side-unit writebacks.
module grf_wport_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                clk,
  input logic                reset,
  grf_wport_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AGE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX    = AGE_W'(STARVE_LIMIT);

  logic [4:0]       fifo_wra [DEPTH];
  logic [31:0]      fifo_wrd [DEPTH];
  logic [31:0]      fifo_pc  [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [AGE_W-1:0] age;

  logic             x_ready;
  logic             fifo_empty;
  logic             w_busy;
  logic             push;
  logic             pop;
  logic             pend_hit;

  logic             d_regwrite;
  logic [4:0]       d_wra;
  logic [31:0]      d_wrd;
  logic [31:0]      d_pc;

  // A slot is occupied when its distance from the head is below the count.
  function automatic logic slot_live(input logic [PTR_W-1:0] slot,
                                     input logic [PTR_W-1:0] head,
                                     input logic [CNT_W-1:0] n);
    logic [PTR_W-1:0] ofs;
    ofs = slot - head;
    return CNT_W'(ofs) < n;
  endfunction

  assign x_ready    = count < FULL_COUNT;
  assign fifo_empty = count == '0;
  assign w_busy     = bus.W_RegWrite && (bus.W_WRA != 5'd0);
  assign push       = bus.X_valid && x_ready && (bus.X_WRA != 5'd0);
  assign pop        = !w_busy && !fifo_empty;

  assign bus.X_ready       = x_ready;
  assign bus.stall_req     = (count == FULL_COUNT) || (age == AGE_MAX);
  assign bus.pend_stall    = pend_hit;
  assign bus.D_RegWrite    = d_regwrite;
  assign bus.D_WRA         = d_wra;
  assign bus.D_WRD         = d_wrd;
  assign bus.D_PCWhenWrite = d_pc;

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (slot_live(PTR_W'(i), rd_ptr, count) && (fifo_wra[i] != 5'd0) &&
          ((fifo_wra[i] == bus.D_rs) || (fifo_wra[i] == bus.D_rt))) begin
        pend_hit = 1'b1;
      end
    end
  end

  // Entry storage needs no reset: the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wra[wr_ptr] <= bus.X_WRA;
      fifo_wrd[wr_ptr] <= bus.X_WRD;
      fifo_pc[wr_ptr]  <= bus.X_PC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      age    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Age tracks how long the current head has waited; a new head starts at 0.
      if (fifo_empty || pop) begin
        age <= '0;
      end else if (age != AGE_MAX) begin
        age <= age + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_regwrite <= 1'b0;
      d_wra      <= '0;
      d_wrd      <= '0;
      d_pc       <= '0;
    end else if (w_busy) begin
      d_regwrite <= 1'b1;
      d_wra      <= bus.W_WRA;
      d_wrd      <= bus.W_WRD;
      d_pc       <= bus.W_PC;
    end else if (pop) begin
      d_regwrite <= 1'b1;
      d_wra      <= fifo_wra[rd_ptr];
      d_wrd      <= fifo_wrd[rd_ptr];
      d_pc       <= fifo_pc[rd_ptr];
    end else begin
      d_regwrite <= 1'b0;
      d_wra      <= '0;
      d_wrd      <= '0;
      d_pc       <= '0;
    end
  end

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed bench for grf_wport_arbiter with a queue-based reference model
// checked every falling edge alongside hand-computed expectations.
module tb_grf_wport_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 8;

  typedef struct packed {
    logic [4:0]  wra;
    logic [31:0] wrd;
    logic [31:0] pc;
  } entry_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  entry_t      model_q[$];
  int          model_age = 0;
  logic        exp_we    = 1'b0;
  logic [4:0]  exp_wra   = '0;
  logic [31:0] exp_wrd   = '0;
  logic [31:0] exp_pc    = '0;

  grf_wport_arbiter_if bus ();

  grf_wport_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic w_we, input logic [4:0] w_wra,
                               input logic [31:0] w_wrd, input logic [31:0] w_pc,
                               input logic x_v, input logic [4:0] x_wra,
                               input logic [31:0] x_wrd, input logic [31:0] x_pc);
    bus.W_RegWrite = w_we;
    bus.W_WRA      = w_wra;
    bus.W_WRD      = w_wrd;
    bus.W_PC       = w_pc;
    bus.X_valid    = x_v;
    bus.X_WRA      = x_wra;
    bus.X_WRD      = x_wrd;
    bus.X_PC       = x_pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outputs follow from the queue contents, then the queue
  // advances using the inputs that are held across the coming rising edge.
  always @(negedge clk) begin : scoreboard
    logic   exp_pend;
    logic   popped;
    int     n_before;
    entry_t head;
    if (!reset) begin
      model_q.delete();
      model_age = 0;
      exp_we  = 1'b0;
      exp_wra = '0;
      exp_wrd = '0;
      exp_pc  = '0;
    end
    exp_pend = 1'b0;
    foreach (model_q[k]) begin
      if (model_q[k].wra != 5'd0 && (model_q[k].wra == bus.D_rs || model_q[k].wra == bus.D_rt))
        exp_pend = 1'b1;
    end
    checkOutput("model X_ready", 32'(bus.X_ready), 32'(model_q.size() < DEPTH));
    checkOutput("model stall_req", 32'(bus.stall_req),
                32'((model_q.size() == DEPTH) || (model_age == STARVE_LIMIT)));
    checkOutput("model pend_stall", 32'(bus.pend_stall), 32'(exp_pend));
    checkOutput("model D_RegWrite", 32'(bus.D_RegWrite), 32'(exp_we));
    checkOutput("model D_WRA", 32'(bus.D_WRA), 32'(exp_wra));
    checkOutput("model D_WRD", bus.D_WRD, exp_wrd);
    checkOutput("model D_PCWhenWrite", bus.D_PCWhenWrite, exp_pc);
    if (reset) begin
      n_before = model_q.size();
      popped   = 1'b0;
      if (bus.W_RegWrite && bus.W_WRA != 5'd0) begin
        exp_we  = 1'b1;
        exp_wra = bus.W_WRA;
        exp_wrd = bus.W_WRD;
        exp_pc  = bus.W_PC;
      end else if (n_before > 0) begin
        head    = model_q.pop_front();
        popped  = 1'b1;
        exp_we  = 1'b1;
        exp_wra = head.wra;
        exp_wrd = head.wrd;
        exp_pc  = head.pc;
      end else begin
        exp_we  = 1'b0;
        exp_wra = '0;
        exp_wrd = '0;
        exp_pc  = '0;
      end
      if (bus.X_valid && n_before < DEPTH && bus.X_WRA != 5'd0)
        model_q.push_back(entry_t'({bus.X_WRA, bus.X_WRD, bus.X_PC}));
      if (n_before == 0 || popped)
        model_age = 0;
      else if (model_age < STARVE_LIMIT)
        model_age = model_age + 1;
    end
  end

  initial begin
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 5'd0, 0, 0);
    bus.D_rs = 5'd0;
    bus.D_rt = 5'd0;
    #2;
    checkOutput("reset X_ready", 32'(bus.X_ready), 1);
    checkOutput("reset stall_req", 32'(bus.stall_req), 0);
    checkOutput("reset pend_stall", 32'(bus.pend_stall), 0);
    checkOutput("reset D_RegWrite", 32'(bus.D_RegWrite), 0);
    checkOutput("reset D_WRD", bus.D_WRD, 0);
    tick();
    tick();
    reset = 1'b1;

    // Pipeline write only
    applyStimulus(1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 0, 0);
    tick();
    checkOutput("w-only D_RegWrite", 32'(bus.D_RegWrite), 1);
    checkOutput("w-only D_WRA", 32'(bus.D_WRA), 5);
    checkOutput("w-only D_WRD", bus.D_WRD, 32'h1234);
    checkOutput("w-only D_PC", bus.D_PCWhenWrite, 32'h3000);
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 5'd0, 0, 0);
    tick();
    checkOutput("w-only idle D_RegWrite", 32'(bus.D_RegWrite), 0);

    // Conflict: buffered X waits behind three W writes
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b1, 5'd8, 32'hAA, 32'h100);
    tick();
    checkOutput("conflict e0 no bypass", 32'(bus.D_RegWrite), 0);
    checkOutput("conflict e0 X_ready", 32'(bus.X_ready), 1);
    applyStimulus(1'b1, 5'd3, 32'h11, 32'h200, 1'b0, 5'd0, 0, 0);
    tick();
    checkOutput("conflict e1 D_WRA", 32'(bus.D_WRA), 3);
    applyStimulus(1'b1, 5'd4, 32'h22, 32'h204, 1'b0, 5'd0, 0, 0);
    tick();
    checkOutput("conflict e2 D_WRA", 32'(bus.D_WRA), 4);
    checkOutput("conflict e2 X_ready", 32'(bus.X_ready), 1);
    applyStimulus(1'b1, 5'd6, 32'h33, 32'h208, 1'b0, 5'd0, 0, 0);
    tick();
    checkOutput("conflict e3 D_WRD", bus.D_WRD, 32'h33);
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 5'd0, 0, 0);
    tick();
    checkOutput("conflict e4 D_RegWrite", 32'(bus.D_RegWrite), 1);
    checkOutput("conflict e4 D_WRA", 32'(bus.D_WRA), 8);
    checkOutput("conflict e4 D_WRD", bus.D_WRD, 32'hAA);
    checkOutput("conflict e4 D_PC", bus.D_PCWhenWrite, 32'h100);
    tick();
    checkOutput("conflict e5 D_RegWrite", 32'(bus.D_RegWrite), 0);

    // Full FIFO with W always busy; third request held until a slot frees
    applyStimulus(1'b1, 5'd1, 32'h501, 32'h400, 1'b1, 5'd10, 32'hA0, 32'h500);
    tick();
    checkOutput("full push1 X_ready", 32'(bus.X_ready), 1);
    applyStimulus(1'b1, 5'd2, 32'h502, 32'h404, 1'b1, 5'd11, 32'hB0, 32'h504);
    tick();
    checkOutput("full push2 X_ready", 32'(bus.X_ready), 0);
    checkOutput("full push2 stall_req", 32'(bus.stall_req), 1);
    applyStimulus(1'b1, 5'd7, 32'h503, 32'h408, 1'b1, 5'd12, 32'hC0, 32'h508);
    tick();
    checkOutput("full held X_ready", 32'(bus.X_ready), 0);
    checkOutput("full held D_WRA", 32'(bus.D_WRA), 7);
    tick();
    checkOutput("full held2 X_ready", 32'(bus.X_ready), 0);
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b1, 5'd12, 32'hC0, 32'h508);
    tick();
    checkOutput("full pop A D_WRA", 32'(bus.D_WRA), 10);
    checkOutput("full pop A D_WRD", bus.D_WRD, 32'hA0);
    checkOutput("full pop A X_ready", 32'(bus.X_ready), 1);
    applyStimulus(1'b1, 5'd7, 32'h503, 32'h408, 1'b1, 5'd12, 32'hC0, 32'h508);
    tick();
    checkOutput("full C accepted X_ready", 32'(bus.X_ready), 0);
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 5'd0, 0, 0);
    tick();
    checkOutput("full pop B D_WRA", 32'(bus.D_WRA), 11);
    tick();
    checkOutput("full pop C D_WRA", 32'(bus.D_WRA), 12);
    checkOutput("full pop C D_PC", bus.D_PCWhenWrite, 32'h508);
    tick();
    checkOutput("full drained D_RegWrite", 32'(bus.D_RegWrite), 0);
    checkOutput("full drained stall_req", 32'(bus.stall_req), 0);

    // Starvation: one entry behind a continuously busy W
    applyStimulus(1'b1, 5'd1, 32'h601, 32'h600, 1'b1, 5'd13, 32'hD0, 32'h700);
    tick();
    applyStimulus(1'b1, 5'd1, 32'h601, 32'h600, 1'b0, 5'd0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("starve stall e%0d", k), 32'(bus.stall_req), 32'(k >= STARVE_LIMIT));
    end
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 5'd0, 0, 0);
    tick();
    checkOutput("starve pop D_WRA", 32'(bus.D_WRA), 13);
    checkOutput("starve pop stall_req", 32'(bus.stall_req), 0);

    // Hazard detection against buffered destinations
    applyStimulus(1'b1, 5'd1, 32'h601, 32'h600, 1'b1, 5'd9, 32'h90, 32'h900);
    tick();
    applyStimulus(1'b1, 5'd1, 32'h601, 32'h600, 1'b0, 5'd0, 0, 0);
    bus.D_rs = 5'd9;
    bus.D_rt = 5'd0;
    #1 checkOutput("hazard rs", 32'(bus.pend_stall), 1);
    bus.D_rs = 5'd0;
    bus.D_rt = 5'd9;
    #1 checkOutput("hazard rt", 32'(bus.pend_stall), 1);
    bus.D_rt = 5'd0;
    #1 checkOutput("hazard none", 32'(bus.pend_stall), 0);
    applyStimulus(1'b1, 5'd1, 32'h601, 32'h600, 1'b1, 5'd0, 32'hEE, 32'hE00);
    tick();
    checkOutput("hazard zero-wra X_ready", 32'(bus.X_ready), 1);
    checkOutput("hazard zero-wra pend", 32'(bus.pend_stall), 0);
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 5'd0, 0, 0);
    bus.D_rs = 5'd9;
    #1 checkOutput("hazard popping pend", 32'(bus.pend_stall), 1);
    tick();
    checkOutput("hazard pop D_WRA", 32'(bus.D_WRA), 9);
    checkOutput("hazard after pop pend", 32'(bus.pend_stall), 0);
    tick();
    checkOutput("hazard discarded D_RegWrite", 32'(bus.D_RegWrite), 0);
    bus.D_rs = 5'd0;

    // Reset asserted mid-cycle with a full buffer
    applyStimulus(1'b1, 5'd1, 32'h601, 32'h600, 1'b1, 5'd20, 32'hF1, 32'hF00);
    tick();
    applyStimulus(1'b1, 5'd1, 32'h601, 32'h600, 1'b1, 5'd21, 32'hF2, 32'hF04);
    tick();
    checkOutput("midrst full X_ready", 32'(bus.X_ready), 0);
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 5'd0, 0, 0);
    bus.D_rs = 5'd20;
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst X_ready", 32'(bus.X_ready), 1);
    checkOutput("midrst stall_req", 32'(bus.stall_req), 0);
    checkOutput("midrst D_RegWrite", 32'(bus.D_RegWrite), 0);
    checkOutput("midrst pend_stall", 32'(bus.pend_stall), 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("midrst flushed e%0d", k), 32'(bus.D_RegWrite), 0);
    end
    bus.D_rs = 5'd0;
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b1, 5'd22, 32'h222, 32'h2200);
    tick();
    applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 5'd0, 0, 0);
    tick();
    checkOutput("post-reset push D_WRA", 32'(bus.D_WRA), 22);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
